// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_seq_pkg
// Description : Shared types, default constants and helpers for the staged
//               reset sequencer (state encoding, counter sizing).
// Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

   localparam int DEF_NUM_DOMAINS  = 4;
   localparam int DEF_STAGE_DLY    = 16;
   localparam int DEF_LOCK_FILTER  = 8;
   localparam int DEF_SW_RST_MIN   = 32;
   localparam int DEF_LOCK_TIMEOUT = 65535;

   typedef enum logic [2:0] {
      WAIT_INIT = 3'd0,
      WAIT_LOCK = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      SW_HOLD   = 3'd4,
      SW_ACK    = 3'd5
   } state_e;

   // Width of a counter able to hold the largest of three terminal values.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_lock_filter.sv
`default_nettype none
// ============================================================================
// Module      : lock_filter
// Description : 2-FF synchronizer followed by a saturating run-length filter.
//               lock_ok_o is high once FILTER_LEN consecutive synchronized
//               high samples have been seen and drops on the first low one.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_filter
   import reset_seq_pkg::*;
#(
   parameter int FILTER_LEN = DEF_LOCK_FILTER
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic lock_ok_o
);

   localparam int CW = cnt_width(FILTER_LEN, 1, 1);

   logic          sync1_q;
   logic          sync2_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Bring the asynchronous lock indication into the clock domain.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive high samples, saturating at FILTER_LEN; any low clears.
   always_comb begin
      cnt_d = cnt_q;
      if (!sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q != CW'(FILTER_LEN)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Run-length counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Gating with the live sample makes lock loss visible without extra delay.
   assign lock_ok_o = sync2_q && (cnt_q == CW'(FILTER_LEN));

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Staged multi-domain reset controller. Releases domains in
//               ascending order with STAGE_DLY spacing once init is done and
//               PLL lock is trusted, re-asserts everything on lock loss and
//               services per-domain soft resets over a four-phase REQ/ACK.
//               Optional macro RESET_SEQ_LOCK_TIMEOUT_EN adds a sticky
//               LOCK_TIMEOUT_ERR flag for an over-long wait for lock.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
   parameter int STAGE_DLY   = DEF_STAGE_DLY,
   parameter int LOCK_FILTER = DEF_LOCK_FILTER,
   parameter int SW_RST_MIN  = DEF_SW_RST_MIN
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
   ,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
`endif
) (
   input  logic                   CLK,
   input  logic                   EXT_RST_N,
   input  logic                   INIT_DONE,
   input  logic                   PLL_LOCK,
   input  logic [NUM_DOMAINS-1:0] SW_RST_REQ,
   output logic [NUM_DOMAINS-1:0] SW_RST_ACK,
   output logic [NUM_DOMAINS-1:0] DOMAIN_RESET_N,
   output logic                   ALL_READY
`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
   ,
   output logic                   LOCK_TIMEOUT_ERR
`endif
);

   localparam int CNT_W = cnt_width(STAGE_DLY, SW_RST_MIN, LOCK_FILTER);
   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic [NUM_DOMAINS-1:0] ack_q, ack_d;
   logic                   ready_q, ready_d;
   logic                   init_sync1_q, init_sync2_q;
   logic                   lock_ok;
   logic                   lock_lost;
   logic [IDX_W-1:0]       req_idx;
   logic [NUM_DOMAINS-1:0] keep_mask;

   lock_filter #(
      .FILTER_LEN (LOCK_FILTER)
   ) u_lock_filter (
      .clk_i     (CLK),
      .rst_ni    (EXT_RST_N),
      .async_i   (PLL_LOCK),
      .lock_ok_o (lock_ok)
   );

   // Plain two-flop synchronizer for the init-complete status.
   always_ff @(posedge CLK or negedge EXT_RST_N) begin
      if (!EXT_RST_N) begin
         init_sync1_q <= 1'b0;
         init_sync2_q <= 1'b0;
      end else begin
         init_sync1_q <= INIT_DONE;
         init_sync2_q <= init_sync1_q;
      end
   end

   // Lowest pending request wins; keep_mask preserves the domains below it.
   always_comb begin
      req_idx = '0;
      for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
         if (SW_RST_REQ[i]) req_idx = IDX_W'(i);
      end
      keep_mask = '0;
      for (int i = 0; i < NUM_DOMAINS; i++) begin
         keep_mask[i] = (i < int'(req_idx));
      end
   end

   // Lock only matters once domains have started coming out of reset.
   assign lock_lost = !lock_ok &&
                      ((state_q == RELEASE) || (state_q == RUN) ||
                       (state_q == SW_HOLD) || (state_q == SW_ACK));

   // Next-state and output logic for the sequencing FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      ack_d   = ack_q;
      ready_d = ready_q;
      if (lock_lost) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
         idx_d   = '0;
         dom_d   = '0;
         ack_d   = '0;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            WAIT_INIT: begin
               if (init_sync2_q) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_ok) begin
                  state_d = RELEASE;
                  idx_d   = '0;
                  cnt_d   = '0;
               end
            end
            RELEASE: begin
               if (cnt_q == CNT_W'(STAGE_DLY - 1)) begin
                  dom_d[idx_q] = 1'b1;
                  cnt_d        = '0;
                  if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               if (|SW_RST_REQ) begin
                  idx_d   = req_idx;
                  dom_d   = dom_q & keep_mask;
                  ready_d = 1'b0;
                  cnt_d   = '0;
                  state_d = SW_HOLD;
               end
            end
            SW_HOLD: begin
               if (cnt_q == CNT_W'(SW_RST_MIN - 1)) begin
                  ack_d[idx_q] = 1'b1;
                  cnt_d        = '0;
                  state_d      = SW_ACK;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SW_ACK: begin
               // Re-release restarts at the serviced domain, keeping idx_q.
               if (!SW_RST_REQ[idx_q]) begin
                  ack_d[idx_q] = 1'b0;
                  cnt_d        = '0;
                  state_d      = RELEASE;
               end
            end
            default: begin
               state_d = WAIT_INIT;
            end
         endcase
      end
   end

   // FSM, counter and output registers.
   always_ff @(posedge CLK or negedge EXT_RST_N) begin
      if (!EXT_RST_N) begin
         state_q <= WAIT_INIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         dom_q   <= '0;
         ack_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         ack_q   <= ack_d;
         ready_q <= ready_d;
      end
   end

   assign DOMAIN_RESET_N = dom_q;
   assign SW_RST_ACK     = ack_q;
   assign ALL_READY      = ready_q;

`ifdef RESET_SEQ_LOCK_TIMEOUT_EN
   localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

   logic [TO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic            tmo_err_q, tmo_err_d;

   // Count only while waiting for lock; the error flag is sticky.
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == WAIT_LOCK) begin
         if (tmo_cnt_q != TO_W'(LOCK_TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + TO_W'(1);
         end else begin
            tmo_cnt_d = tmo_cnt_q;
         end
      end
      tmo_err_d = tmo_err_q || (tmo_cnt_d == TO_W'(LOCK_TIMEOUT));
   end

   // Timeout counter and flag registers.
   always_ff @(posedge CLK or negedge EXT_RST_N) begin
      if (!EXT_RST_N) begin
         tmo_cnt_q <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_err_q <= tmo_err_d;
      end
   end

   assign LOCK_TIMEOUT_ERR = tmo_err_q;
`endif

endmodule
`default_nettype wire
